// File: rtl/mcycle_unit_if.sv
`default_nettype none
// ============================================================================
//  Module      : mcycle_unit_if
//  Description : Request/result bundle between the Execute stage and the
//                multi-cycle multiply/divide engine.
//                  i_start     - operation request (held during stall)
//                  i_op        - 00 smul, 01 umul, 10 sdiv, 11 udiv
//                  i_operand1  - multiplicand / dividend
//                  i_operand2  - multiplier / divisor
//                  o_result1   - low product word / quotient
//                  o_result2   - high product word / remainder
//                  o_busy      - stall request to the hazard unit
//  Revision    : 1.0  initial release
// ============================================================================
interface mcycle_unit_if #(
  parameter int WIDTH = 32
);
  logic             i_start;
  logic [1:0]       i_op;
  logic [WIDTH-1:0] i_operand1;
  logic [WIDTH-1:0] i_operand2;
  logic [WIDTH-1:0] o_result1;
  logic [WIDTH-1:0] o_result2;
  logic             o_busy;

  modport master (
    output i_start, i_op, i_operand1, i_operand2,
    input  o_result1, o_result2, o_busy
  );

  modport slave (
    input  i_start, i_op, i_operand1, i_operand2,
    output o_result1, o_result2, o_busy
  );
endinterface
`default_nettype wire

// File: rtl/mcycle_unit.sv
`default_nettype none
// ============================================================================
//  Module      : mcycle_unit
//  Description : Iterative WIDTHxWIDTH multiplier (shift-add, LSB first) and
//                WIDTH/WIDTH restoring divider (MSB first), one bit per cycle.
//                Busy covers the request cycle plus WIDTH compute cycles;
//                results are valid in the DONE cycle and held afterwards.
//  Ports       : clk    - rising-edge clock
//                rst_n  - asynchronous active-low reset
//                bus    - mcycle_unit_if.slave (start/op/operands in,
//                         results/busy out)
//  Config      : MCYCLE_DIV_EN - when defined the divider is built; when
//                undefined divide requests complete in one cycle with zero
//                results.
//  Revision    : 1.0  initial release
// ============================================================================
module mcycle_unit #(
  parameter int WIDTH = 32
) (
  input  wire logic    clk,
  input  wire logic    rst_n,
  mcycle_unit_if.slave bus
);

  localparam int             CW     = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [CW-1:0]  C_LAST = CW'(WIDTH - 1);

  typedef enum logic [1:0] {
    S_IDLE    = 2'd0,
    S_COMPUTE = 2'd1,
    S_DONE    = 2'd2
  } state_t;

  state_t           r_state;
  logic [CW-1:0]    r_count;
  logic             r_sign1;
  logic             r_sign2;
  logic [WIDTH-1:0] r_a;       // |multiplicand|, or dividend shifting into quotient
  logic [WIDTH-1:0] r_b;       // |multiplier| (shifts right), or |divisor|
  // Bit 0 of the accumulator only ever holds the cleared zero that is shifted
  // out on the first iteration, so it is not stored.
  logic [2*WIDTH-1:1] r_acc;
  logic [WIDTH-1:0] r_result1;
  logic [WIDTH-1:0] r_result2;

  // Operand conditioning at acceptance
  logic             w_in_signed;
  logic [WIDTH-1:0] w_mag1;
  logic [WIDTH-1:0] w_mag2;
  logic             w_skip;

  assign w_in_signed = ~bus.i_op[0];
  assign w_mag1 = (w_in_signed && bus.i_operand1[WIDTH-1]) ? -bus.i_operand1 : bus.i_operand1;
  assign w_mag2 = (w_in_signed && bus.i_operand2[WIDTH-1]) ? -bus.i_operand2 : bus.i_operand2;

  // Multiply iteration: add the multiplicand into the high half when the
  // current multiplier bit is set, then shift the whole accumulator right.
  logic [WIDTH:0]     w_mul_sum;
  logic [2*WIDTH-1:0] w_acc_nxt;
  logic [2*WIDTH-1:0] w_prod;

  assign w_mul_sum = {1'b0, r_acc[2*WIDTH-1:WIDTH]} + {1'b0, (r_b[0] ? r_a : {WIDTH{1'b0}})};
  assign w_acc_nxt = {w_mul_sum, r_acc[WIDTH-1:1]};
  assign w_prod    = (r_sign1 ^ r_sign2) ? -w_acc_nxt : w_acc_nxt;

`ifdef MCYCLE_DIV_EN
  logic             r_div;
  logic [WIDTH-1:0] r_rem;

  // Restoring divide iteration. The shifted partial remainder is WIDTH+1
  // bits; the borrow of the trial subtraction selects the quotient bit.
  logic [WIDTH:0]   w_rem_sh;
  logic [WIDTH:0]   w_diff;
  logic             w_qbit;
  logic [WIDTH-1:0] w_rem_nxt;
  logic [WIDTH-1:0] w_q_nxt;

  assign w_rem_sh  = {r_rem, r_a[WIDTH-1]};
  assign w_diff    = w_rem_sh - {1'b0, r_b};
  assign w_qbit    = ~w_diff[WIDTH];
  assign w_rem_nxt = w_qbit ? w_diff[WIDTH-1:0] : w_rem_sh[WIDTH-1:0];
  assign w_q_nxt   = {r_a[WIDTH-2:0], w_qbit};
  assign w_skip    = 1'b0;
`else
  // Without a divider, divide requests finish immediately with zero results.
  assign w_skip    = bus.i_op[1];
`endif

  // Final results with sign correction, captured on the last iteration edge.
  logic [WIDTH-1:0] w_res1;
  logic [WIDTH-1:0] w_res2;

  always_comb begin
    w_res1 = w_prod[WIDTH-1:0];
    w_res2 = w_prod[2*WIDTH-1:WIDTH];
`ifdef MCYCLE_DIV_EN
    if (r_div) begin
      // A zero divisor naturally leaves |dividend| as the remainder; the
      // quotient is forced to all ones regardless of the dividend sign.
      if (r_b == '0)
        w_res1 = '1;
      else
        w_res1 = (r_sign1 ^ r_sign2) ? -w_q_nxt : w_q_nxt;
      w_res2 = r_sign1 ? -w_rem_nxt : w_rem_nxt;
    end
`endif
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state   <= S_IDLE;
      r_count   <= '0;
      r_sign1   <= 1'b0;
      r_sign2   <= 1'b0;
      r_a       <= '0;
      r_b       <= '0;
      r_acc     <= '0;
      r_result1 <= '0;
      r_result2 <= '0;
`ifdef MCYCLE_DIV_EN
      r_div     <= 1'b0;
      r_rem     <= '0;
`endif
    end else begin
      unique case (r_state)
        S_IDLE: begin
          if (bus.i_start) begin
            if (w_skip) begin
              r_result1 <= '0;
              r_result2 <= '0;
              r_state   <= S_DONE;
            end else begin
              r_a     <= w_mag1;
              r_b     <= w_mag2;
              r_sign1 <= w_in_signed & bus.i_operand1[WIDTH-1];
              r_sign2 <= w_in_signed & bus.i_operand2[WIDTH-1];
              r_acc   <= '0;
              r_count <= '0;
`ifdef MCYCLE_DIV_EN
              r_div   <= bus.i_op[1];
              r_rem   <= '0;
`endif
              r_state <= S_COMPUTE;
            end
          end
        end

        S_COMPUTE: begin
          r_count <= r_count + 1'b1;
`ifdef MCYCLE_DIV_EN
          if (r_div) begin
            r_rem <= w_rem_nxt;
            r_a   <= w_q_nxt;
          end else begin
            r_acc <= w_acc_nxt[2*WIDTH-1:1];
            r_b   <= r_b >> 1;
          end
`else
          r_acc <= w_acc_nxt[2*WIDTH-1:1];
          r_b   <= r_b >> 1;
`endif
          if (r_count == C_LAST) begin
            r_result1 <= w_res1;
            r_result2 <= w_res2;
            r_state   <= S_DONE;
          end
        end

        // The requesting instruction is still in Execute, so Start is ignored.
        S_DONE:  r_state <= S_IDLE;

        default: r_state <= S_IDLE;
      endcase
    end
  end

  // Start-to-Busy is combinational in IDLE so the stall starts in the
  // request cycle; reset forces Busy low even with Start held.
  assign bus.o_busy    = rst_n & ((r_state == S_IDLE) ? bus.i_start : (r_state == S_COMPUTE));
  assign bus.o_result1 = r_result1;
  assign bus.o_result2 = r_result2;

endmodule
`default_nettype wire

// File: tb/tb_mcycle_unit.sv
`default_nettype none
// ============================================================================
//  Module      : tb_mcycle_unit
//  Description : Self-checking bench for mcycle_unit. A per-cycle reference
//                model (plain arithmetic on the accepted operands plus the
//                expected busy window) is compared against Busy/Result1/
//                Result2 every cycle; directed operations also check
//                hand-computed literal results and busy-cycle counts.
//  Revision    : 1.0  initial release
// ============================================================================
module tb_mcycle_unit;

`ifdef MCYCLE_DIV_EN
  localparam bit DIV_EN = 1'b1;
`else
  localparam bit DIV_EN = 1'b0;
`endif
  localparam int WIDTH = 32;

  logic clk   = 1'b0;
  logic rst_n = 1'b1;
  int   cyc   = 0;
  int   n_checks = 0;
  int   n_pass   = 0;
  int   rst_pulses = 0;

  mcycle_unit_if #(.WIDTH(WIDTH)) bus ();

  mcycle_unit #(.WIDTH(WIDTH)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus.slave)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
  endtask

  // Reference arithmetic straight from the operation definitions.
  function automatic void model(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b,
                                output logic [31:0] r1, output logic [31:0] r2, output int lat);
    longint sa, sb;
    logic [63:0] p;
    sa  = longint'($signed(a));
    sb  = longint'($signed(b));
    lat = WIDTH + 1;
    r1  = '0;
    r2  = '0;
    if (!op[1]) begin
      if (!op[0]) p = 64'(sa * sb);
      else        p = {32'd0, a} * {32'd0, b};
      r1 = p[31:0];
      r2 = p[63:32];
    end else if (!DIV_EN) begin
      lat = 1;
    end else if (b == 32'd0) begin
      r1 = 32'hFFFF_FFFF;
      r2 = a;
    end else if (!op[0]) begin
      if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) begin
        r1 = 32'h8000_0000;
        r2 = 32'd0;
      end else begin
        r1 = 32'(sa / sb);
        r2 = 32'(sa % sb);
      end
    end else begin
      r1 = a / b;
      r2 = a % b;
    end
  endfunction

  // Per-cycle compare process with its model state.
  int          m_done = -1;
  int          m_seen_rst = 0;
  logic [31:0] m_r1 = '0, m_r2 = '0, m_p1 = '0, m_p2 = '0;

  always @(negedge clk) begin
    logic exp_busy;
    int   lat;
    if (!rst_n) begin
      m_done = -1; m_r1 = '0; m_r2 = '0;
      chk("rst_busy", {63'd0, bus.o_busy}, 64'd0);
      chk("rst_r1", {32'd0, bus.o_result1}, 64'd0);
      chk("rst_r2", {32'd0, bus.o_result2}, 64'd0);
    end else begin
      if (rst_pulses != m_seen_rst) begin
        m_seen_rst = rst_pulses;
        m_done = -1; m_r1 = '0; m_r2 = '0;
      end
      if (cyc == m_done) begin
        m_r1 = m_p1; m_r2 = m_p2;
        exp_busy = 1'b0;
      end else if (cyc < m_done) begin
        exp_busy = 1'b1;
      end else begin
        exp_busy = bus.i_start;
        if (bus.i_start) begin
          model(bus.i_op, bus.i_operand1, bus.i_operand2, m_p1, m_p2, lat);
          m_done = cyc + lat;
        end
      end
      chk("busy", {63'd0, bus.o_busy}, {63'd0, exp_busy});
      chk("result1", {32'd0, bus.o_result1}, {32'd0, m_r1});
      chk("result2", {32'd0, bus.o_result2}, {32'd0, m_r2});
    end
  end

  // Drive the remaining cycles of an operation whose request is already on
  // the bus in the current cycle, then check literal results in DONE.
  task automatic finish_op(input logic [1:0] op, input logic [31:0] e1, input logic [31:0] e2,
                           input bit hold);
    int lat, nb;
    lat = (!DIV_EN && op[1]) ? 1 : WIDTH + 1;
    if (!DIV_EN && op[1]) begin e1 = '0; e2 = '0; end
    nb = 0;
    for (int k = 0; k < lat; k++) begin
      @(negedge clk);
      if (bus.o_busy) nb++;
      @(posedge clk); #1;
      if (k == 0) begin
        // Post-acceptance changes must be ignored.
        bus.i_op       = ~op;
        bus.i_operand1 = $urandom;
        bus.i_operand2 = $urandom;
      end
    end
    if (!hold) bus.i_start = 1'b0;
    @(negedge clk);
    chk("done_busy", {63'd0, bus.o_busy}, 64'd0);
    chk("busy_cycles", 64'(nb), 64'(lat));
    chk("lit_r1", {32'd0, bus.o_result1}, {32'd0, e1});
    chk("lit_r2", {32'd0, bus.o_result2}, {32'd0, e2});
  endtask

  task automatic run_op(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b,
                        input logic [31:0] e1, input logic [31:0] e2, input bit hold);
    @(posedge clk); #1;
    bus.i_start = 1'b1; bus.i_op = op; bus.i_operand1 = a; bus.i_operand2 = b;
    finish_op(op, e1, e2, hold);
  endtask

  initial begin
    bus.i_start = 1'b0; bus.i_op = 2'b00; bus.i_operand1 = '0; bus.i_operand2 = '0;
    #1 rst_n = 1'b0;
    bus.i_start = 1'b1;               // Busy must stay low in reset anyway
    repeat (3) @(posedge clk);
    #1 bus.i_start = 1'b0;
    #1 rst_n = 1'b1;

    run_op(2'b01, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h0000_0001, 32'hFFFF_FFFE, 1'b1);
    run_op(2'b00, 32'hFFFF_FFFD, 32'd7,         32'hFFFF_FFEB, 32'hFFFF_FFFF, 1'b0);
    run_op(2'b00, 32'h8000_0000, 32'h8000_0000, 32'h0000_0000, 32'h4000_0000, 1'b0);
    run_op(2'b01, 32'h1234_5678, 32'h10,        32'h2345_6780, 32'h0000_0001, 1'b0);
    run_op(2'b10, 32'hFFFF_FFF9, 32'd2,         32'hFFFF_FFFD, 32'hFFFF_FFFF, 1'b0);
    run_op(2'b11, 32'd100,       32'd7,         32'd14,        32'd2,         1'b1);
    run_op(2'b10, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 32'h0000_0000, 1'b0);
    run_op(2'b10, 32'h1234_5678, 32'd0,         32'hFFFF_FFFF, 32'h1234_5678, 1'b0);
    run_op(2'b11, 32'h1234_5678, 32'd0,         32'hFFFF_FFFF, 32'h1234_5678, 1'b0);
    run_op(2'b10, 32'd7,         32'hFFFF_FFFE, 32'hFFFF_FFFD, 32'h0000_0001, 1'b0);
    run_op(2'b10, 32'hFFFF_FFF9, 32'hFFFF_FFFE, 32'h0000_0003, 32'hFFFF_FFFF, 1'b0);
    run_op(2'b01, 32'd5,         32'd6,         32'd30,        32'd0,         1'b0);

    // Reset pulsed in cycle 10 of a multiply, Start held through it.
    @(posedge clk); #1;
    bus.i_start = 1'b1; bus.i_op = 2'b01; bus.i_operand1 = 32'hFFFF_FFFF; bus.i_operand2 = 32'd3;
    repeat (10) @(posedge clk);
    #2 rst_n = 1'b0;
    rst_pulses++;
    #1;
    chk("async_rst_busy", {63'd0, bus.o_busy}, 64'd0);
    chk("async_rst_r1", {32'd0, bus.o_result1}, 64'd0);
    chk("async_rst_r2", {32'd0, bus.o_result2}, 64'd0);
    bus.i_op = 2'b00; bus.i_operand1 = 32'hFFFF_FFF9; bus.i_operand2 = 32'd5;
    #1 rst_n = 1'b1;
    finish_op(2'b00, 32'hFFFF_FFDD, 32'hFFFF_FFFF, 1'b0);

    repeat (3) @(posedge clk);
    @(negedge clk);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/mcycle_unit.md
# mcycle_unit

Multi-cycle multiply/divide engine in the Execute stage of the 5-stage pipeline. It accepts a Start request from the decoded instruction and computes a WIDTH×WIDTH product or a WIDTH/WIDTH quotient and remainder over several cycles. It drives Busy into the hazard unit, which stalls Fetch, Decode and Execute and flushes Memory while Busy is high. Results are consumed by the Execute-stage result mux in the cycle Busy falls.

## Interface
- WIDTH, 32, operand and result width.
- CLK  in  1  rising-edge clock.
- RESETn  in  1  asynchronous, active-low reset.
- Start  in  1  request from the Execute-stage instruction; held high by the pipeline while it stalls.
- MCycleOp  in  2  operation select:
  - 00: signed multiply.
  - 01: unsigned multiply.
  - 10: signed divide.
  - 11: unsigned divide.
- Operand1  in  WIDTH  multiplicand, or dividend.
- Operand2  in  WIDTH  multiplier, or divisor.
- Result1  out  WIDTH  low product word, or quotient.
- Result2  out  WIDTH  high product word, or remainder.
- Busy  out  1  high while the operation is incomplete; feeds the hazard unit as M_BusyE.

## Operation
- States: IDLE, COMPUTE, DONE.
- IDLE:
  - Busy = Start (combinational), so the stall begins in the request cycle.
  - On an edge with Start=1:
    - Latch the operation, |Operand1| and |Operand2| (magnitude taken for signed ops only) and the operand sign bits.
    - Clear the count and the accumulator.
    - Go to COMPUTE.
- COMPUTE:
  - Busy = 1.
  - One iteration per cycle, count 0..WIDTH-1.
  - Multiply: shift-add on a 2·WIDTH accumulator, one multiplier bit per cycle, LSB first.
  - Divide: restoring shift-subtract with a WIDTH+1-bit partial remainder, one quotient bit per cycle, MSB first.
  - On the edge where count = WIDTH-1:
    - Apply sign correction and register Result1/Result2.
    - Go to DONE.
- DONE:
  - Busy = 0 and Result1/Result2 are valid.
  - Start is ignored, because the same instruction is still in Execute this cycle.
  - Unconditional return to IDLE.
- Sign rules:
  - Signed product is negated (2·WIDTH two's complement) if the operand signs differ.
  - Quotient is negated if the signs differ.
  - Remainder takes the sign of the dividend.
  - Unsigned ops use no correction.
- Divide by zero, either signedness: Result1 = all ones, Result2 = Operand1 as latched. Normal iteration count.
- Signed overflow, most-negative / -1: Result1 = most-negative value, Result2 = 0. No exception.
- Result1/Result2 hold their value until the next completion. They are not cleared at Start.
- Operand or MCycleOp changes after the accepting edge are ignored.

## Timing
- Reset (RESETn low, asynchronous):
  - State = IDLE, count = 0, Result1 = 0, Result2 = 0.
  - Busy = 0, even if Start = 1.
- Start cycle is cycle 0. Busy is high for cycles 0..WIDTH, which is WIDTH+1 cycles.
- Results are valid and Busy = 0 in cycle WIDTH+1 (DONE).
- Back-to-back ops: the next instruction reaches Execute in cycle WIDTH+2, with the unit in IDLE. It is accepted that cycle.
- Minimum spacing between two acceptances: WIDTH+2 cycles.
- Reset asserted mid-COMPUTE:
  - Operation abandoned, Busy drops immediately, results cleared.
  - After release, the unit is in IDLE. A Start still high is accepted as a new request.
- No combinational path from Operand1, Operand2 or MCycleOp to any output. The only combinational path is Start to Busy.

## Configuration
- MCYCLE_DIV_EN defined: the divide path is built as described above.
- MCYCLE_DIV_EN undefined:
  - No divider hardware is built.
  - MCycleOp[1]=1 goes from IDLE straight to DONE, so Busy is high for cycle 0 only.
  - Result1 = Result2 = 0.
  - Multiply behaviour is unchanged.

## Test plan
- Unsigned multiply, WIDTH=32, 0xFFFFFFFF × 0xFFFFFFFF:
  - Result1 = 0x00000001, Result2 = 0xFFFFFFFE.
  - Busy high exactly 33 cycles; results valid in cycle 33.
- Signed multiply, -3 × 7:
  - Result1 = 0xFFFFFFEB, Result2 = 0xFFFFFFFF.
- Division:
  - Signed -7 / 2: Result1 = 0xFFFFFFFD, Result2 = 0xFFFFFFFF.
  - Unsigned 100 / 7: Result1 = 14, Result2 = 2.
  - Signed 0x80000000 / 0xFFFFFFFF: Result1 = 0x80000000, Result2 = 0.
- Divide by zero, 0x12345678 / 0 (both signednesses):
  - Result1 = 0xFFFFFFFF, Result2 = 0x12345678, 33 busy cycles.
- Handshake:
  - Start held high through DONE: no restart, Busy = 0 in cycle 33.
  - Start re-asserted with a new operation in cycle 34: accepted, Busy high cycles 34..66.
- Reset and configuration:
  - RESETn pulsed low at cycle 10 of a multiply: Busy = 0 and results = 0 asynchronously. The next Start completes correctly.
  - MCYCLE_DIV_EN undefined: 100 / 7 gives Busy for 1 cycle and results 0.
